// File: rtl/bullet_pkg.sv
// Shared constants and types for the bullet sprite scheduler.
// Slot record, travel direction and screen geometry.
package bullet_pkg;

  localparam int SPRITE_DIM = 7;
  localparam int SCREEN_W   = 640;
  localparam int SCREEN_H   = 480;
  localparam logic [3:0] TRANSPARENT_IDX = 4'd0;

  // Furthest legal top-left corner that keeps the sprite on screen
  localparam int X_MAX = SCREEN_W - 8;
  localparam int Y_MAX = SCREEN_H - 8;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef struct packed {
    logic       valid;
    logic [9:0] x;
    logic [9:0] y;
    dir_t       dir;
  } bullet_slot_t;

  typedef enum logic {
    ST_IDLE,
    ST_UPDATE
  } fsm_t;

endpackage

// File: rtl/bullet_hit_finder.sv
// Per-slot sprite box compare, priority select, ROM address.
// Optional multi-hit flag when BULLET_COLLIDE_EN is defined.
module bullet_hit_finder
  import bullet_pkg::*;
#(
  parameter int NUM_BULLETS = 4
) (
  input  bullet_slot_t slots [NUM_BULLETS],
  input  logic [9:0]   draw_x,
  input  logic [9:0]   draw_y,
  output logic         hit,
  output logic [5:0]   rom_address
`ifdef BULLET_COLLIDE_EN
  ,
  output logic         multi
`endif
);

  logic [NUM_BULLETS-1:0] hits;
  logic [2:0]             ox;
  logic [2:0]             oy;

  // 11-bit box compare so x+7 never wraps
  always_comb begin
    hits = '0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      hits[i] = slots[i].valid
        && ({1'b0, draw_x} >= {1'b0, slots[i].x})
        && ({1'b0, draw_x} <
            {1'b0, slots[i].x} + 11'(SPRITE_DIM))
        && ({1'b0, draw_y} >= {1'b0, slots[i].y})
        && ({1'b0, draw_y} <
            {1'b0, slots[i].y} + 11'(SPRITE_DIM));
    end
  end

  // Lowest index wins; offsets are 0..6 inside a hit
  always_comb begin
    hit = 1'b0;
    ox  = '0;
    oy  = '0;
    for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
      if (hits[i]) begin
        hit = 1'b1;
        ox  = 3'(draw_x - slots[i].x);
        oy  = 3'(draw_y - slots[i].y);
      end
    end
    rom_address = {3'b0, oy} * 6'd7 + {3'b0, ox};
  end

`ifdef BULLET_COLLIDE_EN
  logic [3:0] cnt;

  // Count overlapping hits for the collision flag
  always_comb begin
    cnt = '0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      cnt = cnt + 4'(hits[i]);
    end
    multi = (cnt > 4'd1);
  end
`endif

endmodule

// File: rtl/bullet_sprite_scheduler.sv
// Bullet slot table, per-frame mover FSM and pixel lookup.
// Define BULLET_COLLIDE_EN to add the registered collide output.
module bullet_sprite_scheduler
  import bullet_pkg::*;
#(
  parameter int NUM_BULLETS = 4,
  parameter int SPEED       = 2
) (
  input  logic                   vga_clk,
  input  logic                   reset_n,
  input  logic [9:0]             DrawX,
  input  logic [9:0]             DrawY,
  input  logic                   blank,
  input  logic                   frame_start,
  input  logic                   spawn_valid,
  output logic                   spawn_ready,
  input  logic [9:0]             spawn_x,
  input  logic [9:0]             spawn_y,
  input  logic [1:0]             spawn_dir,
  output logic [5:0]             rom_address,
  input  logic [3:0]             rom_q,
  output logic                   pix_valid,
  output logic [3:0]             pix_index,
  output logic [NUM_BULLETS-1:0] active_mask
`ifdef BULLET_COLLIDE_EN
  ,
  output logic                   collide
`endif
);

  localparam int IW =
    (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;

  bullet_slot_t  slots [NUM_BULLETS];
  bullet_slot_t  cur;
  bullet_slot_t  moved;
  bullet_slot_t  fresh;
  fsm_t          state;
  fsm_t          state_nx;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_nx;
  logic [IW-1:0] free_idx;
  logic          any_free;
  logic          spawn_fire;
  logic          upd_en;
  logic          hit;
  logic          hit_q;
  logic          blank_q;

  // Lowest free slot and occupancy mask
  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
      if (!slots[i].valid) begin
        any_free = 1'b1;
        free_idx = IW'(i);
      end
    end
    for (int i = 0; i < NUM_BULLETS; i++) begin
      active_mask[i] = slots[i].valid;
    end
  end

  assign spawn_ready =
    reset_n & (state == ST_IDLE) & any_free;
  assign spawn_fire = spawn_valid & spawn_ready;

  // FSM state and slot cursor
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  // Next state: one slot per cycle during UPDATE
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    upd_en   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (frame_start) begin
          state_nx = ST_UPDATE;
          idx_nx   = '0;
        end
      end
      ST_UPDATE: begin
        upd_en = 1'b1;
        if (idx == IW'(NUM_BULLETS - 1)) begin
          state_nx = ST_IDLE;
          idx_nx   = '0;
        end else begin
          idx_nx = idx + IW'(1);
        end
      end
    endcase
  end

  // Move the visited slot, retiring it at the screen edge
  always_comb begin
    cur   = slots[idx];
    moved = cur;
    if (cur.valid) begin
      unique case (cur.dir)
        DIR_UP: begin
          if ({1'b0, cur.y} < 11'(SPEED)) moved.valid = 1'b0;
          else moved.y = cur.y - 10'(SPEED);
        end
        DIR_DOWN: begin
          if ({1'b0, cur.y} + 11'(SPEED) > 11'(Y_MAX))
            moved.valid = 1'b0;
          else moved.y = cur.y + 10'(SPEED);
        end
        DIR_LEFT: begin
          if ({1'b0, cur.x} < 11'(SPEED)) moved.valid = 1'b0;
          else moved.x = cur.x - 10'(SPEED);
        end
        DIR_RIGHT: begin
          if ({1'b0, cur.x} + 11'(SPEED) > 11'(X_MAX))
            moved.valid = 1'b0;
          else moved.x = cur.x + 10'(SPEED);
        end
      endcase
    end
  end

  // Incoming spawn record
  always_comb begin
    fresh.valid = 1'b1;
    fresh.x     = spawn_x;
    fresh.y     = spawn_y;
    fresh.dir   = dir_t'(spawn_dir);
  end

  // Slot table: spawn only in IDLE, move only in UPDATE
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_BULLETS; i++) begin
        slots[i] <= '0;
      end
    end else begin
      if (spawn_fire) slots[free_idx] <= fresh;
      if (upd_en) slots[idx] <= moved;
    end
  end

`ifdef BULLET_COLLIDE_EN
  logic multi;

  bullet_hit_finder #(
    .NUM_BULLETS (NUM_BULLETS)
  ) u_hit (
    .slots       (slots),
    .draw_x      (DrawX),
    .draw_y      (DrawY),
    .hit         (hit),
    .rom_address (rom_address),
    .multi       (multi)
  );

  // Collision flag aligned with the ROM read
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) collide <= 1'b0;
    else collide <= multi & blank;
  end
`else
  bullet_hit_finder #(
    .NUM_BULLETS (NUM_BULLETS)
  ) u_hit (
    .slots       (slots),
    .draw_x      (DrawX),
    .draw_y      (DrawY),
    .hit         (hit),
    .rom_address (rom_address)
  );
`endif

  // Align hit and blank with the 1-cycle ROM latency
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_q   <= 1'b0;
      blank_q <= 1'b0;
    end else begin
      hit_q   <= hit;
      blank_q <= blank;
    end
  end

  assign pix_valid =
    hit_q & blank_q & (rom_q != TRANSPARENT_IDX);
  assign pix_index = pix_valid ? rom_q : '0;

endmodule

// File: tb/tb_bullet_sprite_scheduler.sv
// Directed plus randomized bench for bullet_sprite_scheduler.
// Reference model tracks bullets as plain integer records.
module tb_bullet_sprite_scheduler;

  localparam int N   = 4;
  localparam int SPD = 2;

  logic         vga_clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [9:0]   DrawX = '0;
  logic [9:0]   DrawY = '0;
  logic         blank = 1'b0;
  logic         frame_start = 1'b0;
  logic         spawn_valid = 1'b0;
  logic         spawn_ready;
  logic [9:0]   spawn_x = '0;
  logic [9:0]   spawn_y = '0;
  logic [1:0]   spawn_dir = '0;
  logic [5:0]   rom_address;
  logic [3:0]   rom_q = '0;
  logic         pix_valid;
  logic [3:0]   pix_index;
  logic [N-1:0] active_mask;
`ifdef BULLET_COLLIDE_EN
  logic         collide;
`endif

  int checks = 0;
  int errors = 0;

  int mv [N];
  int mx [N];
  int my [N];
  int md [N];

  bullet_sprite_scheduler #(
    .NUM_BULLETS (N),
    .SPEED       (SPD)
  ) dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .blank       (blank),
    .frame_start (frame_start),
    .spawn_valid (spawn_valid),
    .spawn_ready (spawn_ready),
    .spawn_x     (spawn_x),
    .spawn_y     (spawn_y),
    .spawn_dir   (spawn_dir),
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .pix_valid   (pix_valid),
    .pix_index   (pix_index),
`ifdef BULLET_COLLIDE_EN
    .collide     (collide),
`endif
    .active_mask (active_mask)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  function automatic int free_slot();
    for (int i = 0; i < N; i++)
      if (mv[i] == 0) return i;
    return -1;
  endfunction

  function automatic logic [N-1:0] mask();
    logic [N-1:0] m;
    for (int i = 0; i < N; i++) m[i] = (mv[i] != 0);
    return m;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < N; i++) begin
      mv[i] = 0; mx[i] = 0; my[i] = 0; md[i] = 0;
    end
  endfunction

  function automatic void model_load(int x, int y, int d);
    int s;
    s = free_slot();
    mv[s] = 1; mx[s] = x; my[s] = y; md[s] = d;
  endfunction

  // One frame: every live bullet steps or leaves the screen
  function automatic void model_frame();
    int nx, ny;
    for (int i = 0; i < N; i++) begin
      if (mv[i] != 0) begin
        nx = mx[i]; ny = my[i];
        case (md[i])
          0: ny -= SPD;
          1: ny += SPD;
          2: nx -= SPD;
          default: nx += SPD;
        endcase
        if (nx < 0 || ny < 0 || nx > 632 || ny > 472) mv[i] = 0;
        else begin mx[i] = nx; my[i] = ny; end
      end
    end
  endfunction

  task automatic lookup(input int X, input int Y,
                        output int h, output int a,
                        output int c);
    h = 0; a = 0; c = 0;
    for (int i = 0; i < N; i++) begin
      if (mv[i] != 0 && X >= mx[i] && X < mx[i] + 7 &&
          Y >= my[i] && Y < my[i] + 7) begin
        c++;
        if (h == 0) begin
          h = 1;
          a = (Y - my[i]) * 7 + (X - mx[i]);
        end
      end
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    spawn_valid = 1'b0;
    frame_start = 1'b0;
    model_clear();
    tick();
    tick();
    reset_n = 1'b1;
    #1;
  endtask

  task automatic spawn(input int x, input int y, input int d);
    int ok;
    spawn_x = 10'(x); spawn_y = 10'(y); spawn_dir = 2'(d);
    spawn_valid = 1'b1;
    #1;
    ok = (free_slot() >= 0);
    chk("spawn_ready", 32'(spawn_ready), 32'(ok));
    tick();
    spawn_valid = 1'b0;
    if (ok != 0) model_load(x, y, d);
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    model_frame();
    repeat (N) tick();
    chk("mask_after_frame", 32'(active_mask), 32'(mask()));
    chk("ready_after_frame", 32'(spawn_ready),
        32'(free_slot() >= 0));
  endtask

  task automatic probe(input int X, input int Y,
                       input int b, input int r);
    int h, a, c, pv;
    DrawX = 10'(X); DrawY = 10'(Y); blank = b[0];
    #1;
    lookup(X, Y, h, a, c);
    chk("rom_address", 32'(rom_address), 32'(a));
    tick();
    rom_q = 4'(r);
    #1;
    pv = (h != 0 && b != 0 && r != 0) ? 1 : 0;
    chk("pix_valid", 32'(pix_valid), 32'(pv));
    chk("pix_index", 32'(pix_index), pv != 0 ? 32'(r) : 32'd0);
`ifdef BULLET_COLLIDE_EN
    chk("collide", 32'(collide), 32'(c >= 2 && b != 0));
`endif
  endtask

  initial begin
    int s, x, y, op;
    model_clear();

    // Reset values while held
    #2;
    chk("rst_ready", 32'(spawn_ready), 32'd0);
    chk("rst_pv", 32'(pix_valid), 32'd0);
    chk("rst_pi", 32'(pix_index), 32'd0);
    chk("rst_mask", 32'(active_mask), 32'd0);
    chk("rst_addr", 32'(rom_address), 32'd0);
    do_reset();
    chk("ready_after_rst", 32'(spawn_ready), 32'd1);

    // First spawn moves up by SPEED
    spawn(100, 50, 0);
    frame();
    chk("mask_0001", 32'(active_mask), 32'h1);
    probe(103, 51, 1, 7);

    // Fill with spawn_valid held
    spawn_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: begin spawn_x = 10'd300; spawn_y = 10'd300;
                 spawn_dir = 2'd3; end
        1: begin spawn_x = 10'd200; spawn_y = 10'd100;
                 spawn_dir = 2'd1; end
        default: begin spawn_x = 10'd0; spawn_y = 10'd1;
                       spawn_dir = 2'd0; end
      endcase
      #1;
      chk("fill_ready", 32'(spawn_ready), 32'd1);
      tick();
      model_load(int'(spawn_x), int'(spawn_y), int'(spawn_dir));
    end
    chk("full_ready", 32'(spawn_ready), 32'd0);
    spawn_x = 10'd50; spawn_y = 10'd60; spawn_dir = 2'd2;
    tick();
    tick();
    chk("full_hold", 32'(spawn_ready), 32'd0);
    chk("full_mask", 32'(active_mask), 32'hF);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    model_frame();
    repeat (N) tick();
    chk("retire_mask", 32'(active_mask), 32'h7);
    chk("retire_ready", 32'(spawn_ready), 32'd1);
    tick();
    spawn_valid = 1'b0;
    model_load(50, 60, 2);
    chk("fifth_mask", 32'(active_mask), 32'hF);
    probe(52, 61, 1, 3);

    // ROM address and transparency
    do_reset();
    spawn(10, 10, 1);
    probe(13, 12, 1, 5);
    probe(13, 12, 1, 0);
    probe(13, 12, 0, 9);
    probe(17, 12, 1, 4);

    // Priority between overlapping slots
    do_reset();
    spawn(200, 200, 0);
    spawn(400, 400, 0);
    spawn(200, 200, 1);
    probe(203, 203, 1, 6);
    probe(203, 203, 1, 0);

    // Spawn and frame_start together
    do_reset();
    spawn_x = 10'd300; spawn_y = 10'd300; spawn_dir = 2'd1;
    spawn_valid = 1'b1;
    frame_start = 1'b1;
    #1;
    chk("sim_ready", 32'(spawn_ready), 32'd1);
    tick();
    spawn_valid = 1'b0;
    frame_start = 1'b0;
    model_load(300, 300, 1);
    model_frame();
    repeat (N) tick();
    chk("sim_mask", 32'(active_mask), 32'h1);
    probe(300, 302, 1, 2);

    // Reset in the middle of an UPDATE pass
    spawn(120, 120, 3);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    tick();
    reset_n = 1'b0;
    DrawX = 10'd121; DrawY = 10'd121;
    #1;
    model_clear();
    chk("mid_mask", 32'(active_mask), 32'd0);
    chk("mid_ready", 32'(spawn_ready), 32'd0);
    chk("mid_pv", 32'(pix_valid), 32'd0);
    chk("mid_pi", 32'(pix_index), 32'd0);
    chk("mid_addr", 32'(rom_address), 32'd0);
    tick();
    reset_n = 1'b1;
    #1;
    chk("mid_ready_rel", 32'(spawn_ready), 32'd1);
    tick();
    chk("mid_idle", 32'(active_mask), 32'd0);

    // Randomized traffic against the model
    for (int it = 0; it < 300; it++) begin
      op = $urandom_range(0, 9);
      if (op <= 2) begin
        spawn($urandom_range(0, 632), $urandom_range(0, 472),
              $urandom_range(0, 3));
      end else if (op == 3) begin
        frame();
      end else begin
        s = $urandom_range(0, N - 1);
        if (mv[s] != 0 && $urandom_range(0, 3) != 0) begin
          x = mx[s] + $urandom_range(0, 8) - 1;
          y = my[s] + $urandom_range(0, 8) - 1;
          if (x < 0) x = 0;
          if (y < 0) y = 0;
        end else begin
          x = $urandom_range(0, 639);
          y = $urandom_range(0, 479);
        end
        probe(x, y, $urandom_range(0, 1), $urandom_range(0, 15));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/bullet_sprite_scheduler.md
BULLET_SPRITE_SCHEDULER -- requirements
Module: bullet_sprite_scheduler

Interface
REQ-001 SHALL have parameter NUM_BULLETS, default 4, number of bullet slots (range 1..8).
REQ-002 SHALL have parameter SPEED, default 2, pixels moved per frame.
REQ-003 SHALL have port vga_clk  in  1  sole clock; all state on its rising edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports DrawX, DrawY  in  10 each  current pixel coordinate.
REQ-006 SHALL have port blank  in  1  1 = active display region.
REQ-007 SHALL have port frame_start  in  1  one-cycle pulse at start of vertical blanking.
REQ-008 SHALL have spawn_valid (in, 1), spawn_ready (out, 1), spawn_x and spawn_y (in, 10 each), spawn_dir (in, 2: 0 up, 1 down, 2 left, 3 right).
REQ-009 SHALL have rom_address  out  6  address to the shared 7x7 bullet ROM (1-cycle read latency), and rom_q  in  4  ROM palette index.
REQ-010 SHALL have pix_valid  out  1  opaque bullet pixel; pix_index  out  4  palette index; active_mask  out  NUM_BULLETS  slot occupancy.

Function
REQ-011 Slot table SHALL hold valid, x, y and dir per slot; slot (x,y) is the sprite's top-left corner.
REQ-012 spawn_ready SHALL be 1 only when the FSM is IDLE and at least one slot is free.
REQ-013 On spawn_valid & spawn_ready, the lowest-index free slot SHALL load spawn_x/y/dir and become valid on the next edge.
REQ-014 Table full: spawn_ready=0 and the request SHALL be held off, not dropped.
REQ-015 FSM states: IDLE, UPDATE; IDLE->UPDATE on frame_start; UPDATE visits slot 0..NUM_BULLETS-1, one per cycle, then returns to IDLE.
REQ-016 frame_start while in UPDATE SHALL be ignored.
REQ-017 Spawn and frame_start in the same cycle: spawn SHALL be accepted; the new slot is moved in the UPDATE pass that follows.
REQ-018 UPDATE SHALL move a valid slot by SPEED in dir; it SHALL retire (valid=0) instead when the move would give x<0, y<0, x>632 or y>472; no wrap-around.
REQ-019 Lookup: a slot hits when valid, x<=DrawX<x+7 and y<=DrawY<y+7 (11-bit compare, no overflow); the lowest-index hit wins.
REQ-020 rom_address SHALL equal (DrawY-y)*7 + (DrawX-x) of the winning slot, 0 if no hit, combinational from DrawX/DrawY.
REQ-021 Hit and blank SHALL be registered one cycle to align with rom_q; pix_valid = hit_q & blank_q & (rom_q != 0); pix_index = rom_q when pix_valid, else 0.
REQ-022 Pixel latency SHALL be exactly 1 vga_clk from DrawX/DrawY to pix_valid/pix_index.
REQ-023 Index 0 SHALL be transparent; a transparent pixel of the winning slot does not fall through to a lower-priority slot.

Reset
REQ-024 reset_n low SHALL clear all slots, set FSM IDLE, and drive spawn_ready=0 during reset and 1 after, pix_valid=0, pix_index=0, active_mask=0, collide=0.
REQ-025 Reset mid-UPDATE SHALL abandon the pass; no partial move persists.

Configuration
REQ-026 Macro BULLET_COLLIDE_EN SHALL, when defined, add output collide (1 bit, registered, aligned with pix_valid) = 1 when two or more slots hit the same active pixel.
REQ-027 Without BULLET_COLLIDE_EN, the port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-028 Package bullet_pkg SHALL hold: SPRITE_DIM=7, SCREEN_W=640, SCREEN_H=480, TRANSPARENT_IDX=0, dir_t enum, bullet_slot_t struct.
REQ-029 Sub-module bullet_hit_finder SHALL implement the combinational per-slot compare, priority select and rom_address generation.

Verification
REQ-030 Reset, then spawn (100,50,up); at frame_start -> within NUM_BULLETS+1 cycles slot0 y=48, active_mask=0001.
REQ-031 Spawn 4 bullets with spawn_valid held -> spawn_ready=0 after the 4th accept; 5th accepted only after a retire.
REQ-032 Slot at (0,1) moving up, SPEED=2 -> retired on next UPDATE, active_mask bit clears.
REQ-033 Slot0 at (10,10); drive DrawX=13, DrawY=12, blank=1 -> rom_address=17; rom_q=5 -> pix_valid=1, pix_index=5 one cycle later; rom_q=0 -> pix_valid=0.
REQ-034 Slots 0 and 2 both at (200,200); pixel (203,203) -> slot 0 address used; with BULLET_COLLIDE_EN, collide=1 aligned with pix_valid.
REQ-035 Assert reset_n mid-UPDATE -> all outputs at reset values immediately; spawn_ready=1 the first cycle after release.
